// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory boot controller.
package imem_pkg;

  localparam int IMEM_DEPTH  = 4096;
  localparam int IMEM_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } boot_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler shared by the header and payload phases.
// word is only meaningful while word_done is high (the 4th byte is being accepted).
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  assign word_done = byte_en & (cnt == 2'd3);
  assign word      = {byte_in, acc};

  // Byte counter and shift register; older bytes move toward the LSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (byte_en) begin
      cnt <= cnt + 2'd1;
      acc <= {byte_in, acc[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed byte stream into instruction memory,
// then hands the memory read port to the CPU fetch interface.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  output logic [31:0] fetch_rdata,
  output logic        fetch_rvalid,
  output logic        boot_done,
  output logic        load_err,
  output logic [31:0] mem_raddr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  localparam logic [31:0]     DEPTH_W  = DEPTH;
  localparam logic [ADDR_W:0] WCNT_ONE = (ADDR_W + 1)'(1);

  boot_state_t       state;
  logic [31:0]       len;
  logic [ADDR_W:0]   wcnt;
  logic              byte_en;
  logic              pack_clr;
  logic              word_done;
  logic [31:0]       word;
  logic [ADDR_W-1:0] fetch_idx;
  logic              unused_addr_bits;

  assign byte_en   = in_valid & in_ready;
  // Only a start that is actually honoured may clear a half-built word.
  assign pack_clr  = start & ((state == IDLE) | (state == RUN) | (state == ERR));
  assign fetch_idx = fetch_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  // fetch_ready is only ever high in RUN, where no write can be pending.
  assign mem_ren   = fetch_valid & fetch_ready;
  assign mem_raddr = mem_ren ? {{(32-ADDR_W){1'b0}}, fetch_idx} : 32'd0;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .byte_en   (byte_en),
    .byte_in   (in_byte),
    .word      (word),
    .word_done (word_done)
  );

  // Boot FSM with registered stream, status and write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= 32'd0;
      wcnt        <= {(ADDR_W+1){1'b0}};
      in_ready    <= 1'b0;
      fetch_ready <= 1'b0;
      boot_done   <= 1'b0;
      load_err    <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= 32'd0;
      mem_wdata   <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            in_ready <= 1'b1;
          end
        end
        HDR: begin
          if (word_done) begin
            len <= word;
            if (word == 32'd0) begin
              state       <= RUN;
              in_ready    <= 1'b0;
              fetch_ready <= 1'b1;
              boot_done   <= 1'b1;
            end else if (word > DEPTH_W) begin
              state    <= ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state <= LOAD;
              wcnt  <= {(ADDR_W+1){1'b0}};
            end
          end
        end
        LOAD: begin
          if (word_done) begin
            mem_we    <= 1'b1;
            mem_waddr <= {{(32-ADDR_W){1'b0}}, wcnt[ADDR_W-1:0]};
            mem_wdata <= word;
            wcnt      <= wcnt + WCNT_ONE;
            if ({{(31-ADDR_W){1'b0}}, wcnt} == (len - 32'd1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state       <= RUN;
          fetch_ready <= 1'b1;
          boot_done   <= 1'b1;
        end
        RUN: begin
          if (start) begin
            state       <= HDR;
            in_ready    <= 1'b1;
            fetch_ready <= 1'b0;
            boot_done   <= 1'b0;
          end
        end
        ERR: begin
          if (start) begin
            state    <= HDR;
            in_ready <= 1'b1;
            load_err <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready    <= 1'b0;
          fetch_ready <= 1'b0;
          boot_done   <= 1'b0;
          load_err    <= 1'b0;
        end
      endcase
    end
  end

  // Fetch response: capture memory data the cycle a fetch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= 32'd0;
    end else begin
      fetch_rvalid <= mem_ren;
      if (mem_ren) begin
        fetch_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural instruction memory.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_valid = 1'b0;
  logic        in_ready, fetch_ready, fetch_rvalid, boot_done, load_err, mem_ren, mem_we;
  logic [31:0] fetch_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int we_count, overlap_cnt, ren_outside;
  int we_base;
  bit tb_ready = 1'b0;

  logic [31:0] mem [0:4095];
  logic [4095:0] mem_wr;
  logic [11:0] rd_idx;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] idx;
    logic [31:0] data;
  } fvec_t;
  fvec_t fv [6];

  imem_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata), .fetch_rvalid(fetch_rvalid),
    .boot_done(boot_done), .load_err(load_err), .mem_raddr(mem_raddr), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  // Memory model: never-written words read back as C0DE_<index>.
  assign rd_idx    = mem_raddr[11:0];
  assign mem_rdata = mem_ren ? (mem_wr[rd_idx] ? mem[rd_idx] : (32'hC0DE_0000 | {20'd0, rd_idx})) : 32'd0;

  always @(posedge clk) begin
    if (!tb_ready) begin
      mem_wr      <= '0;
      we_count    <= 0;
      overlap_cnt <= 0;
      ren_outside <= 0;
    end else begin
      if (mem_we) begin
        mem[mem_waddr[11:0]]    <= mem_wdata;
        mem_wr[mem_waddr[11:0]] <= 1'b1;
        we_count                <= we_count + 1;
      end
      if (mem_we && mem_ren) overlap_cnt <= overlap_cnt + 1;
      if (mem_ren && !boot_done) ren_outside <= ren_outside + 1;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int g;
    n = 0;
    if (gaps) begin
      g = int'($urandom_range(0, 2));
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check1("in_ready_timeout", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[7:0], gaps);
      t = t >> 8;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    fv[0] = '{32'h0000_0000, 32'd0,     32'h1234_5678};
    fv[1] = '{32'h0000_0005, 32'd1,     32'hDEAD_BEEF};
    fv[2] = '{32'h0000_4000, 32'd0,     32'h1234_5678};
    fv[3] = '{32'hFFFF_C007, 32'd1,     32'hDEAD_BEEF};
    fv[4] = '{32'h0000_3FFC, 32'd4095,  32'hC0DE_0FFF};
    fv[5] = '{32'h0000_0008, 32'd2,     32'hC0DE_0002};

    // Reset state
    repeat (2) @(negedge clk);
    tb_ready = 1'b1;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_fetch_ready", fetch_ready, 1'b0);
    check1("rst_boot_done", boot_done, 1'b0);
    check1("rst_load_err", load_err, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_fetch_rvalid", fetch_rvalid, 1'b0);
    check32("rst_mem_waddr", mem_waddr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_fetch_rdata", fetch_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("idle_in_ready", in_ready, 1'b0);

    // Two-word load with a fetch request held throughout
    pulse_start();
    check1("hdr_in_ready", in_ready, 1'b1);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h4;
    send_word(32'd2, 1'b0);
    check1("load_in_ready", in_ready, 1'b1);
    check1("load_fetch_ready", fetch_ready, 1'b0);
    check1("load_mem_ren", mem_ren, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    check1("w0_mem_we", mem_we, 1'b1);
    check32("w0_waddr", mem_waddr, 32'd0);
    check32("w0_wdata", mem_wdata, 32'h1234_5678);
    send_word(32'hDEAD_BEEF, 1'b0);
    in_valid    = 1'b0;
    fetch_valid = 1'b0;
    check1("flush_mem_we", mem_we, 1'b1);
    check1("flush_in_ready", in_ready, 1'b0);
    check1("flush_boot_done", boot_done, 1'b0);
    check32("w1_waddr", mem_waddr, 32'd1);
    check32("w1_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check1("run_boot_done", boot_done, 1'b1);
    check1("run_fetch_ready", fetch_ready, 1'b1);
    check1("run_mem_we", mem_we, 1'b0);
    check32("mem0", mem[0], 32'h1234_5678);
    check32("mem1", mem[1], 32'hDEAD_BEEF);
    check32("we_count_2", we_count, 32'd2);

    // Single fetch of byte address 4
    fetch_valid = 1'b1;
    fetch_addr  = 32'h4;
    #1;
    check1("f4_mem_ren", mem_ren, 1'b1);
    check32("f4_raddr", mem_raddr, 32'd1);
    @(negedge clk);
    fetch_valid = 1'b0;
    check1("f4_rvalid", fetch_rvalid, 1'b1);
    check32("f4_rdata", fetch_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check1("f4_rvalid_drop", fetch_rvalid, 1'b0);

    // Back-to-back fetch table
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = fv[i].addr;
      #1;
      check1("tbl_mem_ren", mem_ren, 1'b1);
      check32("tbl_raddr", mem_raddr, fv[i].idx);
      if (i > 0) begin
        check1("tbl_rvalid", fetch_rvalid, 1'b1);
        check32("tbl_rdata", fetch_rdata, fv[i-1].data);
      end
      @(negedge clk);
    end
    fetch_valid = 1'b0;
    check1("tbl_rvalid_last", fetch_rvalid, 1'b1);
    check32("tbl_rdata_last", fetch_rdata, fv[5].data);
    @(negedge clk);
    check1("tbl_rvalid_drop", fetch_rvalid, 1'b0);

    // Start coincident with an accepted fetch, then reload with stream gaps
    start       = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    #1;
    check1("sf_mem_ren", mem_ren, 1'b1);
    @(negedge clk);
    start       = 1'b0;
    fetch_valid = 1'b0;
    check1("sf_rvalid", fetch_rvalid, 1'b1);
    check32("sf_rdata", fetch_rdata, 32'h1234_5678);
    check1("sf_boot_done", boot_done, 1'b0);
    check1("sf_fetch_ready", fetch_ready, 1'b0);
    check1("sf_in_ready", in_ready, 1'b1);
    we_base = we_count;
    send_word(32'd3, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    send_word(32'h99AA_BBCC, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check1("gap_boot_done", boot_done, 1'b1);
    check32("gap_we_count", we_count - we_base, 32'd3);
    check32("gap_mem0", mem[0], 32'h1122_3344);
    check32("gap_mem1", mem[1], 32'h5566_7788);
    check32("gap_mem2", mem[2], 32'h99AA_BBCC);

    // Zero-length program goes straight to RUN
    pulse_start();
    check1("z_boot_done_drop", boot_done, 1'b0);
    we_base = we_count;
    send_word(32'd0, 1'b0);
    in_valid = 1'b0;
    check1("z_boot_done", boot_done, 1'b1);
    check1("z_fetch_ready", fetch_ready, 1'b1);
    check1("z_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check32("z_we_count", we_count - we_base, 32'd0);

    // Oversized length: sticky error, stream and fetch both blocked
    pulse_start();
    send_word(32'd4097, 1'b0);
    check1("err_load_err", load_err, 1'b1);
    check1("err_in_ready", in_ready, 1'b0);
    check1("err_fetch_ready", fetch_ready, 1'b0);
    in_byte     = 8'h55;
    fetch_valid = 1'b1;
    repeat (3) @(negedge clk);
    check1("err_sticky", load_err, 1'b1);
    check1("err_mem_ren", mem_ren, 1'b0);
    check1("err_rvalid", fetch_rvalid, 1'b0);
    check1("err_boot_done", boot_done, 1'b0);
    fetch_valid = 1'b0;
    in_valid    = 1'b0;
    pulse_start();
    check1("err_clear", load_err, 1'b0);
    check1("err_hdr_in_ready", in_ready, 1'b1);

    // Maximum legal length is accepted, then reset lands mid-word
    send_word(32'd4096, 1'b0);
    check1("max_load_err", load_err, 1'b0);
    check1("max_in_ready", in_ready, 1'b1);
    we_base = we_count;
    send_word(32'h0BAD_F00D, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check1("mid_rst_in_ready", in_ready, 1'b0);
    check1("mid_rst_mem_we", mem_we, 1'b0);
    check32("mid_rst_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    check32("mid_rst_we_count", we_count - we_base, 32'd1);
    check32("mid_rst_mem0", mem[0], 32'h0BAD_F00D);
    check32("mid_rst_mem1", mem[1], 32'h5566_7788);
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_idle", in_ready, 1'b0);
    check1("post_rst_boot_done", boot_done, 1'b0);

    // Fresh single-word load after reset
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hAABB_CCDD, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check1("fresh_boot_done", boot_done, 1'b1);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    @(negedge clk);
    fetch_valid = 1'b0;
    check1("fresh_rvalid", fetch_rvalid, 1'b1);
    check32("fresh_rdata", fetch_rdata, 32'hAABB_CCDD);

    check32("we_ren_overlap", overlap_cnt, 32'd0);
    check32("ren_outside_run", ren_outside, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
